// File: rtl/bus_pkg.sv
// Shared bus definitions used by masters, slaves and the arbiter.
// Holds arbiter state encodings, control-word field positions and the
// burst-code-to-beat-count mapping.
package bus_pkg;

  // Control word field positions
  localparam int unsigned CTRL_WAIT     = 0;
  localparam int unsigned CTRL_WE       = 1;
  localparam int unsigned CTRL_BURST_LO = 2;
  localparam int unsigned CTRL_BURST_HI = 4;
  localparam int unsigned BURST_CODE_W  = CTRL_BURST_HI - CTRL_BURST_LO + 1;
  localparam int unsigned BURST_LEN_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_GRANT      = 3'd1,
    ST_ADDR       = 3'd2,
    ST_SLAVE_WAIT = 3'd3,
    ST_DATA       = 3'd4,
    ST_RELEASE    = 3'd5
  } bus_state_e;

  // Codes 0..3 give 1,2,4,8 beats; larger codes clamp to 8
  function automatic logic [BURST_LEN_W-1:0] burst_code_to_len(
    input logic [BURST_CODE_W-1:0] code
  );
    if (code >= BURST_CODE_W'(3)) return BURST_LEN_W'(8);
    return BURST_LEN_W'(BURST_LEN_W'(1) << code);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin selector.
// Ports: req (per-master request), rr_ptr (highest-priority index),
//        grant_c (one-hot winner), idx_c (winner index), valid_c (any request).
module rr_picker #(
  parameter int unsigned NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [2:0]             rr_ptr,
  output logic [NUM_MASTERS-1:0] grant_c,
  output logic [2:0]             idx_c,
  output logic                   valid_c
);

  logic       hi_found;
  logic [2:0] hi_idx;
  logic       lo_found;
  logic [2:0] lo_idx;

  // Lowest requester at/after rr_ptr wins; otherwise wrap to lowest overall
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    grant_c  = '0;
    for (int i = int'(NUM_MASTERS) - 1; i >= 0; i--) begin
      if (req[i] && (3'(i) >= rr_ptr)) begin
        hi_found = 1'b1;
        hi_idx   = 3'(i);
      end
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = 3'(i);
      end
    end
    valid_c = hi_found | lo_found;
    idx_c   = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (valid_c && (idx_c == 3'(i))) grant_c[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter and master-side multiplexer.
// Ports: clk/rst (sync active-high), req/ack (request, registered one-hot grant),
//        m_bus/m_ctrl (flattened master outputs), s_wait (slave wait),
//        bus_shared/ctrl_shared (owner's bus/ctrl, combinational from state),
//        grant_idx, bus_busy, timeout_err (registered status).
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_MASTERS  = 4,
  parameter int unsigned BUS_WIDTH    = 32,
  parameter int unsigned CTRL_WIDTH   = 8,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            req,
  output logic [NUM_MASTERS-1:0]            ack,
  input  logic [NUM_MASTERS*BUS_WIDTH-1:0]  m_bus,
  input  logic [NUM_MASTERS*CTRL_WIDTH-1:0] m_ctrl,
  input  logic                              s_wait,
  output logic [BUS_WIDTH-1:0]              bus_shared,
  output logic [CTRL_WIDTH-1:0]             ctrl_shared,
  output logic [2:0]                        grant_idx,
  output logic                              bus_busy,
  output logic                              timeout_err
);

  bus_state_e               state_q, state_d;
  logic [2:0]               owner_q, owner_d;
  logic [2:0]               rr_ptr_q, rr_ptr_d;
  logic [BURST_LEN_W-1:0]   burst_len_q, burst_len_d;
  logic [2:0]               beat_cnt_q, beat_cnt_d;
  logic [7:0]               wait_cnt_q, wait_cnt_d;
  logic [NUM_MASTERS-1:0]   ack_q, ack_d;
  logic                     busy_q, busy_d;
  logic                     timeout_q, timeout_d;

  logic [NUM_MASTERS-1:0]   pick_grant;
  logic [2:0]               pick_idx;
  logic                     pick_valid;
  logic                     owner_req_c;
  logic                     tenure_c;
  logic [7:0]               wait_inc_c;
  logic                     wait_hit_c;
  logic                     last_beat_c;

  rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .grant_c (pick_grant),
    .idx_c   (pick_idx),
    .valid_c (pick_valid)
  );

  // Owner's request line, used for early-drop detection
  always_comb begin
    owner_req_c = 1'b0;
    for (int i = 0; i < int'(NUM_MASTERS); i++) begin
      if (owner_q == 3'(i)) owner_req_c = req[i];
    end
  end

  assign tenure_c    = (state_q == ST_GRANT) || (state_q == ST_ADDR) ||
                       (state_q == ST_SLAVE_WAIT) || (state_q == ST_DATA);
  assign wait_inc_c  = (wait_cnt_q == 8'hFF) ? 8'hFF : wait_cnt_q + 8'd1;
  assign wait_hit_c  = (wait_inc_c >= 8'(WAIT_TIMEOUT));
  assign last_beat_c = (beat_cnt_q == 3'(burst_len_q - BURST_LEN_W'(1)));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_len_q <= '0;
      beat_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_len_q <= burst_len_d;
      beat_cnt_q  <= beat_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state logic; an owner dropping req abandons the tenure from any busy state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (pick_valid) state_d = ST_GRANT;
      ST_GRANT:      state_d = owner_req_c ? ST_ADDR : ST_RELEASE;
      ST_ADDR:       state_d = owner_req_c ? ST_SLAVE_WAIT : ST_RELEASE;
      ST_SLAVE_WAIT: begin
        if (!owner_req_c)    state_d = ST_RELEASE;
        else if (!s_wait)    state_d = ST_DATA;
        else if (wait_hit_c) state_d = ST_RELEASE;
      end
      ST_DATA:       if (!owner_req_c || last_beat_c) state_d = ST_RELEASE;
      ST_RELEASE:    state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Next values for counters and registered outputs
  always_comb begin
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_len_d = burst_len_q;
    beat_cnt_d  = beat_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    timeout_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) owner_d = pick_idx;
        beat_cnt_d = '0;
        wait_cnt_d = '0;
      end
      ST_ADDR: begin
        burst_len_d = burst_code_to_len(ctrl_shared[CTRL_BURST_HI:CTRL_BURST_LO]);
        wait_cnt_d  = '0;
      end
      ST_SLAVE_WAIT: begin
        wait_cnt_d = wait_inc_c;
        beat_cnt_d = '0;
        timeout_d  = owner_req_c && s_wait && wait_hit_c;
      end
      ST_DATA:    beat_cnt_d = beat_cnt_q + 3'd1;
      ST_RELEASE: rr_ptr_d = (owner_q == 3'(NUM_MASTERS - 1)) ? 3'd0 : owner_q + 3'd1;
      default:    ;
    endcase
    busy_d = (state_d == ST_GRANT) || (state_d == ST_ADDR) ||
             (state_d == ST_SLAVE_WAIT) || (state_d == ST_DATA);
    if (state_q == ST_IDLE) ack_d = pick_grant;
    else                    ack_d = busy_d ? (NUM_MASTERS'(1) << owner_q) : '0;
  end

  // Owner-to-shared-bus mux; the slave-side wait bit is never forwarded
  always_comb begin
    bus_shared  = '0;
    ctrl_shared = '0;
    if (tenure_c) begin
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
        if (owner_q == 3'(i)) begin
          bus_shared  = m_bus[i*BUS_WIDTH +: BUS_WIDTH];
          ctrl_shared = m_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
        end
      end
      ctrl_shared[CTRL_WAIT] = 1'b0;
    end
  end

  assign ack         = ack_q;
  assign bus_busy    = busy_q;
  assign grant_idx   = owner_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: per-cycle expectations are queued as
// each scenario's stimulus is applied and consumed every cycle at negedge.
module tb_bus_arbiter;

  localparam int unsigned NM = 4;
  localparam int unsigned BW = 32;
  localparam int unsigned CW = 8;
  localparam int unsigned WT = 5;

  logic            clk;
  logic            rst;
  logic [NM-1:0]   req;
  logic [NM-1:0]   ack;
  logic [NM*BW-1:0] m_bus;
  logic [NM*CW-1:0] m_ctrl;
  logic            s_wait;
  logic [BW-1:0]   bus_shared;
  logic [CW-1:0]   ctrl_shared;
  logic [2:0]      grant_idx;
  logic            bus_busy;
  logic            timeout_err;

  logic [31:0]     cyc = '0;
  logic [2:0]      code [NM];

  typedef struct {
    bit          busy;
    int unsigned owner;
    bit          to;
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bus_arbiter #(
    .NUM_MASTERS(NM), .BUS_WIDTH(BW), .CTRL_WIDTH(CW), .WAIT_TIMEOUT(WT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .m_bus(m_bus), .m_ctrl(m_ctrl),
    .s_wait(s_wait), .bus_shared(bus_shared), .ctrl_shared(ctrl_shared),
    .grant_idx(grant_idx), .bus_busy(bus_busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Each master's bus carries its index plus a running value, so every beat differs
  function automatic logic [BW-1:0] pat(input int unsigned i, input logic [31:0] c);
    return (32'(i) << 24) | 32'h00A5_0000 | (c & 32'h0000_FFFF);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(NM); i++) begin
      m_bus[i*BW +: BW]  = pat(i, cyc);
      m_ctrl[i*CW +: CW] = {3'b000, code[i], 1'(i % 2), 1'b1};
    end
  end

  task automatic push_busy(input int unsigned owner, input int n);
    exp_t e;
    e.busy = 1'b1; e.owner = owner; e.to = 1'b0;
    repeat (n) sb_q.push_back(e);
  endtask

  task automatic push_rel(input bit to);
    exp_t e;
    e.busy = 1'b0; e.owner = 0; e.to = to;
    sb_q.push_back(e);
  endtask

  task automatic push_idle(input int n);
    repeat (n) push_rel(1'b0);
  endtask

  // Advance n cycles, scoring each cycle's outputs against the scoreboard head
  task automatic tick(input int n);
    exp_t e;
    logic [NM-1:0] ea;
    logic [BW-1:0] eb;
    logic [CW-1:0] ec;
    repeat (n) begin
      @(negedge clk);
      if (sb_q.size() > 0) e = sb_q.pop_front();
      else begin e.busy = 1'b0; e.owner = 0; e.to = 1'b0; end
      ea = e.busy ? (NM'(1) << e.owner) : '0;
      eb = e.busy ? pat(e.owner, cyc) : '0;
      ec = e.busy ? {3'b000, code[e.owner], 1'(e.owner % 2), 1'b0} : '0;
      n_checks++;
      if (ack !== ea) begin
        n_fail++; $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, ack, ea);
      end
      n_checks++;
      if (bus_busy !== e.busy) begin
        n_fail++; $display("FAIL bus_busy cyc=%0d got=%b exp=%b", cyc, bus_busy, e.busy);
      end
      n_checks++;
      if (timeout_err !== e.to) begin
        n_fail++; $display("FAIL timeout_err cyc=%0d got=%b exp=%b", cyc, timeout_err, e.to);
      end
      n_checks++;
      if (bus_shared !== eb) begin
        n_fail++; $display("FAIL bus_shared cyc=%0d got=%h exp=%h", cyc, bus_shared, eb);
      end
      n_checks++;
      if (ctrl_shared !== ec) begin
        n_fail++; $display("FAIL ctrl_shared cyc=%0d got=%h exp=%h", cyc, ctrl_shared, ec);
      end
      if (e.busy) begin
        n_checks++;
        if (grant_idx !== 3'(e.owner)) begin
          n_fail++; $display("FAIL grant_idx cyc=%0d got=%0d exp=%0d", cyc, grant_idx, e.owner);
        end
      end
      #1;
    end
  endtask

  task automatic drained(input string name);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s scoreboard_left got=%0d exp=0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; s_wait = 1'b0;
    for (int i = 0; i < int'(NM); i++) code[i] = 3'd0;
    tick(2);
    n_checks++;
    if (grant_idx !== 3'd0) begin
      n_fail++; $display("FAIL reset_grant_idx got=%0d exp=0", grant_idx);
    end
    rst = 1'b0;
    tick(3);
    drained("reset");
  endtask

  // All four request continuously: 0,1,2,3,0 with one IDLE between tenures
  task automatic test_round_robin();
    for (int i = 0; i < int'(NM); i++) code[i] = 3'd1;
    s_wait = 1'b0;
    tick(1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push_busy(k % 4, 5); push_rel(1'b0); push_idle(1);
    end
    tick(34); req = '0; tick(1);
    drained("round_robin");
  endtask

  // rr_ptr=2 after serving master 1; then 1 and 3 together -> 3 first
  task automatic test_rr_priority();
    for (int i = 0; i < int'(NM); i++) code[i] = 3'd0;
    s_wait = 1'b0;
    tick(1);
    req = 4'b0010;
    push_busy(1, 4); push_rel(1'b0); push_idle(1);
    push_busy(3, 4); push_rel(1'b0); push_idle(1);
    push_busy(1, 4); push_rel(1'b0); push_idle(1);
    tick(5); req = 4'b1010;
    tick(6); req = 4'b0010;
    tick(6); req = '0;
    tick(1);
    drained("rr_priority");
  endtask

  // Master 0, 4-beat burst, slave holds wait for two SLAVE_WAIT cycles
  task automatic test_single_burst();
    code[0] = 3'b010;
    s_wait = 1'b1;
    tick(1);
    req = 4'b0001;
    push_busy(0, 9); push_rel(1'b0); push_idle(2);
    tick(5); s_wait = 1'b0;
    tick(5); req = '0;
    tick(2);
    drained("single_burst");
  endtask

  // Wait held high: one timeout pulse in RELEASE, 5 cycles after SLAVE_WAIT entry
  task automatic test_timeout();
    int pulses;
    pulses = 0;
    code[2] = 3'd0;
    s_wait = 1'b1;
    tick(1);
    req = 4'b0100;
    push_busy(2, 2 + WT); push_rel(1'b1); push_idle(1);
    for (int c = 1; c <= 9; c++) begin
      tick(1);
      if (timeout_err === 1'b1) pulses++;
      if (c == 8) req = '0;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++; $display("FAIL timeout_pulses got=%0d exp=1", pulses);
    end
    s_wait = 1'b0;
    drained("timeout");
  endtask

  // Owner 3 drops req on its 2nd beat; waiting master 1 follows two cycles later
  task automatic test_early_drop();
    code[3] = 3'b010; code[1] = 3'd0;
    s_wait = 1'b0;
    tick(1);
    req = 4'b1010;
    push_busy(3, 5); push_rel(1'b0); push_idle(1);
    push_busy(1, 4); push_rel(1'b0); push_idle(1);
    tick(5); req = 4'b0010;
    tick(7); req = '0;
    tick(1);
    drained("early_drop");
  endtask

  // Reset during DATA: no RELEASE cycle, rr_ptr returns to 0
  task automatic test_reset_mid();
    code[2] = 3'b010; code[1] = 3'd0;
    s_wait = 1'b0;
    tick(1);
    req = 4'b0100;
    push_busy(2, 5); push_idle(1);
    push_busy(1, 4); push_rel(1'b0); push_idle(1);
    push_busy(2, 7); push_rel(1'b0); push_idle(1);
    tick(5); rst = 1'b1;
    tick(1);
    n_checks++;
    if (grant_idx !== 3'd0) begin
      n_fail++; $display("FAIL reset_mid_grant_idx got=%0d exp=0", grant_idx);
    end
    rst = 1'b0; req = 4'b0110;
    tick(5); req = 4'b0100;
    tick(9); req = '0;
    tick(1);
    drained("reset_mid");
  endtask

  // Burst code 6 clamps to 8 beats
  task automatic test_burst_clamp();
    code[3] = 3'd6;
    s_wait = 1'b0;
    tick(1);
    req = 4'b1000;
    push_busy(3, 11); push_rel(1'b0); push_idle(1);
    tick(12); req = '0;
    tick(1);
    drained("burst_clamp");
  endtask

  initial begin
    rst = 1'b1; req = '0; s_wait = 1'b0;
    test_reset();
    test_round_robin();
    test_rr_priority();
    test_single_burst();
    test_timeout();
    test_early_drop();
    test_reset_mid();
    test_burst_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
